// File: rtl/ritc_dac_servo_if.sv
// Measurement input and DAC servo write port for the RITC DAC servo loop.
// The controller uses the master view and the DAC/measurement side uses the slave view.
interface ritc_dac_servo_if;
   logic               meas_valid;
   logic               meas_ritc;
   logic signed [15:0] meas_err;
   logic               loader_busy;
   logic               servo_addr;
   logic               servo_wr;
   logic               servo_update;
   logic [11:0]        servo;

   modport master (
      input  meas_valid, meas_ritc, meas_err, loader_busy,
      output servo_addr, servo_wr, servo_update, servo
   );

   modport slave (
      output meas_valid, meas_ritc, meas_err, loader_busy,
      input  servo_addr, servo_wr, servo_update, servo
   );
endinterface

// File: rtl/ritc_dac_servo.sv
// Closed-loop integrator for the two RITC DAC values. It writes changed values into the servo
// BRAM slot, pulses a reload, follows the loader busy handshake and lets software pause the loop.
module ritc_dac_servo #(
   parameter int INIT_VALUE   = 2048,
   parameter int MIN_VAL      = 0,
   parameter int MAX_VAL      = 4095,
   parameter int GAIN_SHIFT   = 4,
   parameter int MAX_STEP     = 64,
   parameter int DEADBAND     = 2,
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        enable_i,
   input  logic        pause_i,
   output logic        paused_o,
   input  logic        set_wr_i,
   input  logic        set_ritc_i,
   input  logic [11:0] set_val_i,
   input  logic        status_clr_i,
   output logic [11:0] val_r0_o,
   output logic [11:0] val_r1_o,
   output logic [7:0]  drop_count_o,
   output logic        timeout_o,
   ritc_dac_servo_if.master bus
);

   localparam int CW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic signed [15:0] STEP_HI = 16'(MAX_STEP);
   localparam logic signed [15:0] STEP_LO = -STEP_HI;
   localparam logic signed [15:0] DB_HI   = 16'(DEADBAND);
   localparam logic signed [15:0] DB_LO   = -DB_HI;
   localparam logic signed [17:0] VAL_MIN = 18'(MIN_VAL);
   localparam logic signed [17:0] VAL_MAX = 18'(MAX_VAL);

   typedef enum logic [2:0] {IDLE, CALC, APPLY, WRITE, UPDATE, WAIT_HI, WAIT_LO} state_t;

   state_t             state_q;
   logic               ritc_q;
   logic signed [15:0] err_q;
   logic signed [15:0] step_q;
   logic [11:0]        val_q [2];
   logic [CW-1:0]      cnt_q;
   logic               paused_q;
   logic               servo_wr_q;
   logic               servo_update_q;
   logic               servo_addr_q;
   logic [11:0]        servo_q;
   logic [7:0]         drop_q;
   logic               timeout_q;

   logic signed [15:0] shifted;
   logic signed [15:0] step_d;
   logic signed [17:0] sum;
   logic [11:0]        cur_val;
   logic [11:0]        new_d;
   logic               in_dead;
   logic               accept;
   logic               drop;
   logic [CW-1:0]      cnt_inc;

   always_comb begin
      shifted = err_q >>> GAIN_SHIFT;
      step_d  = shifted;
      if (shifted > STEP_HI)
         step_d = STEP_HI;
      else if (shifted < STEP_LO)
         step_d = STEP_LO;
      in_dead = (err_q >= DB_LO) && (err_q <= DB_HI);
      cur_val = ritc_q ? val_q[1] : val_q[0];
      // 18-bit headroom keeps out-of-range presets plus a full step from wrapping
      sum     = 18'($signed({6'd0, cur_val})) + 18'(step_q);
      new_d   = sum[11:0];
      if (sum < VAL_MIN)
         new_d = VAL_MIN[11:0];
      else if (sum > VAL_MAX)
         new_d = VAL_MAX[11:0];
      accept  = bus.meas_valid && enable_i && !pause_i && (state_q == IDLE);
      drop    = bus.meas_valid && enable_i && !accept;
      cnt_inc = cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q        <= IDLE;
         ritc_q         <= 1'b0;
         err_q          <= '0;
         step_q         <= '0;
         val_q[0]       <= 12'(INIT_VALUE);
         val_q[1]       <= 12'(INIT_VALUE);
         cnt_q          <= '0;
         paused_q       <= 1'b0;
         servo_wr_q     <= 1'b0;
         servo_update_q <= 1'b0;
         servo_addr_q   <= 1'b0;
         servo_q        <= '0;
         drop_q         <= '0;
         timeout_q      <= 1'b0;
      end else begin
         servo_wr_q     <= 1'b0;
         servo_update_q <= 1'b0;
         paused_q       <= pause_i && (state_q == IDLE);

         if (status_clr_i)
            drop_q <= '0;
         else if (drop && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
         if (status_clr_i)
            timeout_q <= 1'b0;

         if (set_wr_i && paused_q)
            val_q[set_ritc_i] <= set_val_i;

         case (state_q)
            IDLE: if (accept) begin
               ritc_q  <= bus.meas_ritc;
               err_q   <= bus.meas_err;
               state_q <= CALC;
            end
            CALC: begin
               step_q  <= step_d;
               state_q <= in_dead ? IDLE : APPLY;
            end
            APPLY: if (new_d == cur_val) begin
               state_q <= IDLE;
            end else begin
               val_q[ritc_q] <= new_d;
               servo_wr_q    <= 1'b1;
               servo_addr_q  <= ritc_q;
               servo_q       <= new_d;
               state_q       <= WRITE;
            end
            WRITE: begin
               servo_update_q <= 1'b1;
               state_q        <= UPDATE;
            end
            UPDATE: begin
               cnt_q   <= '0;
               state_q <= WAIT_HI;
            end
            WAIT_HI: if (bus.loader_busy) begin
               state_q <= WAIT_LO;
            end else begin
               cnt_q <= cnt_inc;
               if (cnt_inc == CW'(BUSY_TIMEOUT)) begin
                  if (!status_clr_i)
                     timeout_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            WAIT_LO: if (!bus.loader_busy)
               state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign paused_o         = paused_q;
   assign val_r0_o         = val_q[0];
   assign val_r1_o         = val_q[1];
   assign drop_count_o     = drop_q;
   assign timeout_o        = timeout_q;
   assign bus.servo_wr     = servo_wr_q;
   assign bus.servo_update = servo_update_q;
   assign bus.servo_addr   = servo_addr_q;
   assign bus.servo        = servo_q;

endmodule
